fft_frame_sched: RTL

//   Single-clock frame scheduler for the 512-point FFT path; replaces the divided-clock frame FSM.

---
 rtl/fft_frame_sched.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/fft_frame_sched.sv
// Single-clock frame scheduler for the 512-point FFT path: input buffer -> core load ->
// process -> output-buffer unload -> buffer clear, paced by a step counter instead of a divided clock.
module fft_frame_sched #(
  parameter int N_PTS    = 512,
  parameter int ADDR_W   = 9,
  parameter int STEP_DIV = 4,
  parameter int TIMEOUT  = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              sample_valid,
  input  logic              buf_full,
  output logic              buf_clear,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              core_load,
  output logic [ADDR_W-1:0] core_addr,
  output logic              core_start,
  input  logic              core_done,
  input  logic              out_busy,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_wr_addr,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic [15:0]       drop_count,
  output logic              timeout_err
);

  localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(N_PTS - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PROC,
    S_WAIT_OUT,
    S_UNLOAD,
    S_CLEAR
  } state_t;

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                frame_done_q, frame_done_d;
  logic [15:0]         frame_count_q, frame_count_d;
  logic [15:0]         drop_count_q, drop_count_d;
  logic                timeout_err_q, timeout_err_d;
  logic                step_end;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      step_q        <= '0;
      ptr_q         <= '0;
      tmo_q         <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      ptr_q         <= ptr_d;
      tmo_q         <= tmo_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    ptr_d         = ptr_q;
    tmo_d         = '0;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;
    timeout_err_d = timeout_err_q;
    step_end      = (step_q == STEP_LAST);

    case (state_q)
      S_IDLE: begin
        step_d = '0;
        ptr_d  = '0;
        if (enable && buf_full) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (step_end) begin
          step_d = '0;
          if (ptr_q == PTR_LAST) begin
            ptr_d   = '0;
            state_d = S_PROC;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      S_PROC: begin
        // A done arriving on the final allowed cycle still takes the normal path.
        if (core_done) begin
          state_d = S_WAIT_OUT;
        end else if (tmo_q == TMO_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = S_CLEAR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WAIT_OUT: begin
        if (!out_busy) begin
          step_d  = '0;
          ptr_d   = '0;
          state_d = S_UNLOAD;
        end
      end
      S_UNLOAD: begin
        if (step_end) begin
          step_d = '0;
          if (ptr_q == PTR_LAST) begin
            ptr_d         = '0;
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
            state_d       = S_CLEAR;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      S_CLEAR: begin
        if (!buf_full) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The cycle that leaves IDLE already belongs to the frame, so its sample is a drop.
    if (sample_valid && ((state_q != S_IDLE) || (state_d != S_IDLE)) &&
        (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  assign core_load   = (state_q == S_LOAD);
  assign core_start  = (state_q == S_PROC);
  assign buf_clear   = (state_q == S_CLEAR);
  assign out_wr_en   = (state_q == S_UNLOAD) && step_end;
  assign rd_addr     = (state_q == S_LOAD) ? ptr_q : '0;
  assign core_addr   = ((state_q == S_LOAD) || (state_q == S_UNLOAD)) ? ptr_q : '0;
  assign out_wr_addr = (state_q == S_UNLOAD) ? ptr_q : '0;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;
  assign timeout_err = timeout_err_q;

endmodule
